arm_control_unit: RTL and testbench

Hardwired finite-state-machine (FSM) control unit for the ARM-subset simulator datapath. It fetches the instruction word and decodes it (in `IR_Out`). For one instruction it then drives every datapath select, enable and memory-handshake signal:

- data-processing, single load/store, or branch/branch-with-link.

It sits between the instruction register, status flags and memory on one side, and the register file, ALU, shifter, ISE (instruction sign/shift extender), MAR (memory address register) and MDR (memory data register) on the other.

---
 rtl/arm_cu_pkg.sv | 109 ++++++++++
 rtl/arm_control_unit_cond_check.sv | 39 +++
 rtl/arm_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_arm_control_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_cu_pkg.sv
// Shared definitions for the ARM-subset hardwired control unit.
// Holds the FSM state enum, the registered control-word layout, ALU opcodes,
// datapath select codes and condition-code encodings.
package arm_cu_pkg;

  typedef enum logic [3:0] {
    ST_RST,
    ST_F1,
    ST_F2,
    ST_F3,
    ST_DEC,
    ST_DP,
    ST_LSA,
    ST_LSM,
    ST_LSW,
    ST_BL,
    ST_BR
  } state_t;

  // Every datapath control line, registered together as one word.
  typedef struct packed {
    logic [1:0] dss;
    logic [1:0] wra;
    logic [1:0] sra;
    logic [1:0] srb;
    logic [1:0] sise;
    logic [1:0] salub;
    logic [3:0] alua;
    logic       mfa;
    logic       rw_ram;
    logic       salu;
    logic       rf_rw;
    logic       ssab;
    logic       ssop;
    logic       sma;
    logic       sta;
    logic       mar_en;
    logic       sr_en;
    logic       mdr_en;
    logic       ir_en;
    logic       sht_en;
    logic       ise_en;
    logic       sgn_en;
    logic       clr;
  } ctrl_t;

  // ALU opcodes (ARM data-processing encoding)
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_RSB = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  // Register-file write-data source
  localparam logic [1:0] DSS_ALU = 2'b00;
  localparam logic [1:0] DSS_MDR = 2'b01;
  localparam logic [1:0] DSS_PA  = 2'b10;

  // Write-register select
  localparam logic [1:0] WRA_RD = 2'b00;
  localparam logic [1:0] WRA_RN = 2'b01;
  localparam logic [1:0] WRA_PC = 2'b10;
  localparam logic [1:0] WRA_LR = 2'b11;

  // Port-A register select
  localparam logic [1:0] SRA_RN = 2'b00;
  localparam logic [1:0] SRA_RD = 2'b01;
  localparam logic [1:0] SRA_PC = 2'b10;
  localparam logic [1:0] SRA_RM = 2'b11;

  // Port-B register select
  localparam logic [1:0] SRB_RM = 2'b00;
  localparam logic [1:0] SRB_RD = 2'b01;
  localparam logic [1:0] SRB_PC = 2'b10;
  localparam logic [1:0] SRB_RS = 2'b11;

  // Extender mode
  localparam logic [1:0] SISE_IMM8ROT = 2'b00;
  localparam logic [1:0] SISE_SHREG   = 2'b01;
  localparam logic [1:0] SISE_IMM12   = 2'b10;
  localparam logic [1:0] SISE_IMM24   = 2'b11;

  // ALU B operand source
  localparam logic [1:0] SALUB_PB   = 2'b00;
  localparam logic [1:0] SALUB_ISE  = 2'b01;
  localparam logic [1:0] SALUB_FOUR = 2'b10;
  localparam logic [1:0] SALUB_MDR  = 2'b11;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/arm_control_unit_cond_check.sv
// Combinational ARM condition evaluator.
// Ports: cond (IR[31:28]), flags ({N,Z,C}); pass = 1 when the instruction executes.
// V is not tracked, so it is taken as 0; NV never executes.
module cond_check
  import arm_cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [2:0] flags,
  output logic       pass
);

  logic n, z, c;
  assign n = flags[2];
  assign z = flags[1];
  assign c = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = 1'b0;
      COND_VC: pass = 1'b1;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = ~n;       // N == V with V = 0
      COND_LT: pass = n;
      COND_GT: pass = ~z & ~n;
      COND_LE: pass = z | n;
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;     // NV
    endcase
  end

endmodule

// File: rtl/arm_control_unit.sv
// Hardwired FSM control unit for the ARM-subset datapath.
// Inputs: CLK, RESET (sync, active-high), IR_Out (instruction), MFC (memory
// done), Flags ({N,Z,C}). Outputs: register/ALU/extender selects, memory
// handshake (MFA, RW_RAM), load/enable strobes and CLR, all registered.
module arm_control_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IR_Out,
  input  logic        MFC,
  input  logic [2:0]  Flags,
  output logic [1:0]  DSS,
  output logic [1:0]  WRA,
  output logic [1:0]  SRA,
  output logic [1:0]  SRB,
  output logic [1:0]  SISE,
  output logic [1:0]  SALUB,
  output logic [3:0]  ALUA,
  output logic        MFA,
  output logic        RW_RAM,
  output logic        SALU,
  output logic        RF_RW,
  output logic        SSAB,
  output logic        SSOP,
  output logic        SMA,
  output logic        STA,
  output logic        MAR_EN,
  output logic        SR_EN,
  output logic        MDR_EN,
  output logic        IR_EN,
  output logic        SHT_EN,
  output logic        ISE_EN,
  output logic        SGN_EN,
  output logic        CLR
);

  import arm_cu_pkg::*;

  state_t state, next_state;
  ctrl_t  ctrl, next_ctrl;
  logic   cond_pass;
  logic   unused_ir_bits;

  assign unused_ir_bits = ^{IR_Out[19:5], IR_Out[3:0]};

  cond_check u_cond_check (
    .cond  (IR_Out[31:28]),
    .flags (Flags),
    .pass  (cond_pass)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_RST: next_state = ST_F1;
      ST_F1:  next_state = ST_F2;
      ST_F2:  if (MFC) next_state = ST_F3;
      ST_F3:  next_state = ST_DEC;
      ST_DEC: begin
        if (!cond_pass)                  next_state = ST_F1;
        else if (IR_Out[27:26] == 2'b00) next_state = ST_DP;
        else if (IR_Out[27:26] == 2'b01) next_state = ST_LSA;
        else if (IR_Out[27:25] == 3'b101) next_state = IR_Out[24] ? ST_BL : ST_BR;
        else                             next_state = ST_F1;
      end
      ST_DP:  next_state = ST_F1;
      ST_LSA: next_state = ST_LSM;
      ST_LSM: if (MFC) next_state = IR_Out[20] ? ST_LSW : ST_F1;
      ST_LSW: next_state = ST_F1;
      ST_BL:  next_state = ST_BR;
      ST_BR:  next_state = ST_F1;
      default: next_state = ST_RST;
    endcase
  end

  // Outputs are decoded from the state being entered and registered with it,
  // so they are Moore outputs of the current state without a decode delay.
  always_comb begin
    next_ctrl = '0;
    case (next_state)
      ST_RST: next_ctrl.clr = 1'b1;
      ST_F1: begin
        next_ctrl.sra    = SRA_PC;
        next_ctrl.sma    = 1'b1;
        next_ctrl.mar_en = 1'b1;
      end
      ST_F2: begin
        next_ctrl.mfa    = 1'b1;
        next_ctrl.rw_ram = 1'b1;
        next_ctrl.mdr_en = 1'b1;
        next_ctrl.ir_en  = 1'b1;
      end
      ST_F3: begin
        next_ctrl.sra   = SRA_PC;
        next_ctrl.salub = SALUB_FOUR;
        next_ctrl.alua  = ALU_ADD;
        next_ctrl.wra   = WRA_PC;
        next_ctrl.rf_rw = 1'b1;
      end
      ST_DEC: begin
        next_ctrl.ise_en = 1'b1;
        next_ctrl.sht_en = 1'b1;
        next_ctrl.ssab   = IR_Out[4];
        next_ctrl.ssop   = IR_Out[25];
        if (IR_Out[27:26] == 2'b00)
          next_ctrl.sise = IR_Out[25] ? SISE_IMM8ROT : SISE_SHREG;
        else if (IR_Out[27:26] == 2'b01)
          next_ctrl.sise = IR_Out[25] ? SISE_SHREG : SISE_IMM12;
        else if (IR_Out[27:25] == 3'b101)
          next_ctrl.sise = SISE_IMM24;
        next_ctrl.sgn_en = (IR_Out[27:25] == 3'b101);
      end
      ST_DP: begin
        next_ctrl.salub = SALUB_ISE;
        next_ctrl.sise  = IR_Out[25] ? SISE_IMM8ROT : SISE_SHREG;
        next_ctrl.alua  = IR_Out[24:21];
        next_ctrl.rf_rw = (IR_Out[24:23] != 2'b10);  // compare/test ops only set flags
        next_ctrl.sr_en = IR_Out[20];
      end
      ST_LSA: begin
        next_ctrl.salub  = SALUB_ISE;
        next_ctrl.sise   = IR_Out[25] ? SISE_SHREG : SISE_IMM12;
        next_ctrl.alua   = IR_Out[23] ? ALU_ADD : ALU_SUB;
        next_ctrl.mar_en = 1'b1;
        if (!IR_Out[20]) begin
          next_ctrl.srb    = SRB_RD;
          next_ctrl.sta    = 1'b1;
          next_ctrl.mdr_en = 1'b1;
        end
      end
      ST_LSM: begin
        next_ctrl.mfa    = 1'b1;
        next_ctrl.rw_ram = IR_Out[20];
        next_ctrl.mdr_en = IR_Out[20];
      end
      ST_LSW: begin
        next_ctrl.dss   = DSS_MDR;
        next_ctrl.rf_rw = 1'b1;
      end
      ST_BL: begin
        next_ctrl.sra   = SRA_PC;
        next_ctrl.dss   = DSS_PA;
        next_ctrl.wra   = WRA_LR;
        next_ctrl.rf_rw = 1'b1;
      end
      ST_BR: begin
        next_ctrl.sra    = SRA_PC;
        next_ctrl.salub  = SALUB_ISE;
        next_ctrl.sise   = SISE_IMM24;
        next_ctrl.sgn_en = 1'b1;
        next_ctrl.alua   = ALU_ADD;
        next_ctrl.wra    = WRA_PC;
        next_ctrl.rf_rw  = 1'b1;
      end
      default: next_ctrl = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_RST;
      ctrl     <= '0;
      ctrl.clr <= 1'b1;
    end else begin
      state <= next_state;
      ctrl  <= next_ctrl;
    end
  end

  assign DSS    = ctrl.dss;
  assign WRA    = ctrl.wra;
  assign SRA    = ctrl.sra;
  assign SRB    = ctrl.srb;
  assign SISE   = ctrl.sise;
  assign SALUB  = ctrl.salub;
  assign ALUA   = ctrl.alua;
  assign MFA    = ctrl.mfa;
  assign RW_RAM = ctrl.rw_ram;
  assign SALU   = ctrl.salu;
  assign RF_RW  = ctrl.rf_rw;
  assign SSAB   = ctrl.ssab;
  assign SSOP   = ctrl.ssop;
  assign SMA    = ctrl.sma;
  assign STA    = ctrl.sta;
  assign MAR_EN = ctrl.mar_en;
  assign SR_EN  = ctrl.sr_en;
  assign MDR_EN = ctrl.mdr_en;
  assign IR_EN  = ctrl.ir_en;
  assign SHT_EN = ctrl.sht_en;
  assign ISE_EN = ctrl.ise_en;
  assign SGN_EN = ctrl.sgn_en;
  assign CLR    = ctrl.clr;

endmodule

// File: tb/tb_arm_control_unit.sv
module tb_arm_control_unit;

  typedef struct packed {
    logic [1:0] dss, wra, sra, srb, sise, salub;
    logic [3:0] alua;
    logic mfa, rw_ram, salu, rf_rw, ssab, ssop, sma, sta;
    logic mar_en, sr_en, mdr_en, ir_en, sht_en, ise_en, sgn_en, clr;
  } ov_t;

  typedef struct {
    string tag;
    ov_t   val;
  } exp_t;

  typedef struct {
    logic [3:0] cond;
    logic [2:0] flags;
    logic       pass;
  } cc_t;

  logic        CLK = 1'b0;
  logic        RESET, MFC;
  logic [31:0] IR_Out;
  logic [2:0]  Flags;
  logic [1:0]  DSS, WRA, SRA, SRB, SISE, SALUB;
  logic [3:0]  ALUA;
  logic MFA, RW_RAM, SALU, RF_RW, SSAB, SSOP, SMA, STA;
  logic MAR_EN, SR_EN, MDR_EN, IR_EN, SHT_EN, ISE_EN, SGN_EN, CLR;

  ov_t  obs;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  arm_control_unit dut (
    .CLK(CLK), .RESET(RESET), .IR_Out(IR_Out), .MFC(MFC), .Flags(Flags),
    .DSS(DSS), .WRA(WRA), .SRA(SRA), .SRB(SRB), .SISE(SISE), .SALUB(SALUB),
    .ALUA(ALUA), .MFA(MFA), .RW_RAM(RW_RAM), .SALU(SALU), .RF_RW(RF_RW),
    .SSAB(SSAB), .SSOP(SSOP), .SMA(SMA), .STA(STA), .MAR_EN(MAR_EN),
    .SR_EN(SR_EN), .MDR_EN(MDR_EN), .IR_EN(IR_EN), .SHT_EN(SHT_EN),
    .ISE_EN(ISE_EN), .SGN_EN(SGN_EN), .CLR(CLR)
  );

  assign obs = {DSS, WRA, SRA, SRB, SISE, SALUB, ALUA, MFA, RW_RAM, SALU, RF_RW,
                SSAB, SSOP, SMA, STA, MAR_EN, SR_EN, MDR_EN, IR_EN, SHT_EN,
                ISE_EN, SGN_EN, CLR};

  // Expected output words, written directly from the state output tables.
  function automatic ov_t e_rst();
    ov_t v = '0; v.clr = 1'b1; return v;
  endfunction
  function automatic ov_t e_f1();
    ov_t v = '0; v.sra = 2'b10; v.sma = 1'b1; v.mar_en = 1'b1; return v;
  endfunction
  function automatic ov_t e_f2();
    ov_t v = '0; v.mfa = 1'b1; v.rw_ram = 1'b1; v.mdr_en = 1'b1; v.ir_en = 1'b1; return v;
  endfunction
  function automatic ov_t e_f3();
    ov_t v = '0; v.sra = 2'b10; v.salub = 2'b10; v.alua = 4'b0100;
    v.wra = 2'b10; v.rf_rw = 1'b1; return v;
  endfunction
  function automatic ov_t e_dec(logic [1:0] sise, logic ssop, logic sgn);
    ov_t v = '0; v.ise_en = 1'b1; v.sht_en = 1'b1; v.ssop = ssop;
    v.sise = sise; v.sgn_en = sgn; return v;
  endfunction
  function automatic ov_t e_bl();
    ov_t v = '0; v.sra = 2'b10; v.dss = 2'b10; v.wra = 2'b11; v.rf_rw = 1'b1; return v;
  endfunction
  function automatic ov_t e_br();
    ov_t v = '0; v.sra = 2'b10; v.salub = 2'b01; v.sise = 2'b11; v.sgn_en = 1'b1;
    v.alua = 4'b0100; v.wra = 2'b10; v.rf_rw = 1'b1; return v;
  endfunction

  task automatic push(input string tag, input ov_t v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  // One rising edge per queued expectation; compare 1 time unit after it.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    ov_t v;
    cc_t cc[10];
    cc[0] = '{4'hC, 3'b000, 1'b1};  // GT
    cc[1] = '{4'hC, 3'b100, 1'b0};
    cc[2] = '{4'h8, 3'b001, 1'b1};  // HI
    cc[3] = '{4'h8, 3'b011, 1'b0};
    cc[4] = '{4'hF, 3'b111, 1'b0};  // NV
    cc[5] = '{4'h7, 3'b000, 1'b1};  // VC
    cc[6] = '{4'h6, 3'b111, 1'b0};  // VS
    cc[7] = '{4'hB, 3'b100, 1'b1};  // LT
    cc[8] = '{4'hD, 3'b000, 1'b0};  // LE
    cc[9] = '{4'h3, 3'b001, 1'b0};  // CC

    RESET = 1'b1; MFC = 1'b1; IR_Out = 32'h0; Flags = 3'b000;
    #2;
    push("rst0", e_rst()); push("rst1", e_rst());
    drain();

    // AND R0, R1, #0
    RESET = 1'b0; IR_Out = 32'hE2010000;
    push("and_f1", e_f1()); push("and_f2", e_f2()); push("and_f3", e_f3());
    push("and_dec", e_dec(2'b00, 1'b1, 1'b0));
    v = '0; v.salub = 2'b01; v.rf_rw = 1'b1;
    push("and_dp", v);
    push("and_next_f1", e_f1());
    drain();

    // Memory wait in F2: MFC low for 3 sampled edges
    MFC = 1'b0;
    push("wait_f2_0", e_f2()); drain();
    push("wait_f2_1", e_f2()); drain();
    push("wait_f2_2", e_f2()); drain();
    push("wait_f2_3", e_f2()); drain();
    MFC = 1'b1;
    push("wait_f3", e_f3());
    push("wait_dec", e_dec(2'b00, 1'b1, 1'b0));
    v = '0; v.salub = 2'b01; v.rf_rw = 1'b1;
    push("wait_dp", v);
    drain();

    // LDREQ R2, [R1, #4] with Z = 1
    IR_Out = 32'h05912004; Flags = 3'b010;
    push("ld_f1", e_f1()); push("ld_f2", e_f2()); push("ld_f3", e_f3());
    push("ld_dec", e_dec(2'b10, 1'b0, 1'b0));
    v = '0; v.salub = 2'b01; v.sise = 2'b10; v.alua = 4'b0100; v.mar_en = 1'b1;
    push("ld_lsa", v);
    v = '0; v.mfa = 1'b1; v.rw_ram = 1'b1; v.mdr_en = 1'b1;
    push("ld_lsm", v);
    v = '0; v.dss = 2'b01; v.rf_rw = 1'b1;
    push("ld_lsw", v);
    push("ld_f1_next", e_f1());
    drain();

    // Same LDREQ with Z = 0: skipped after decode
    Flags = 3'b000;
    push("ldx_f2", e_f2()); push("ldx_f3", e_f3());
    push("ldx_dec", e_dec(2'b10, 1'b0, 1'b0));
    push("ldx_f1", e_f1());
    drain();

    // BL with link
    IR_Out = 32'hEB000002;
    push("bl_f2", e_f2()); push("bl_f3", e_f3());
    push("bl_dec", e_dec(2'b11, 1'b1, 1'b1));
    push("bl_bl", e_bl()); push("bl_br", e_br()); push("bl_f1", e_f1());
    drain();

    // CMP R1, R2
    IR_Out = 32'hE1510002;
    push("cmp_f2", e_f2()); push("cmp_f3", e_f3());
    push("cmp_dec", e_dec(2'b01, 1'b0, 1'b0));
    v = '0; v.salub = 2'b01; v.sise = 2'b01; v.alua = 4'b1010; v.sr_en = 1'b1;
    push("cmp_dp", v);
    push("cmp_f1", e_f1());
    drain();

    // STR R3, [R1, #-8]
    IR_Out = 32'hE5013008;
    push("st_f2", e_f2()); push("st_f3", e_f3());
    push("st_dec", e_dec(2'b10, 1'b0, 1'b0));
    v = '0; v.salub = 2'b01; v.sise = 2'b10; v.alua = 4'b0010; v.mar_en = 1'b1;
    v.srb = 2'b01; v.sta = 1'b1; v.mdr_en = 1'b1;
    push("st_lsa", v);
    v = '0; v.mfa = 1'b1;
    push("st_lsm", v);
    push("st_f1", e_f1());
    drain();

    // Condition table using plain branches
    foreach (cc[i]) begin
      IR_Out = {cc[i].cond, 28'hA000000};
      Flags  = cc[i].flags;
      push($sformatf("cc%0d_f2", i), e_f2());
      push($sformatf("cc%0d_f3", i), e_f3());
      push($sformatf("cc%0d_dec", i), e_dec(2'b11, 1'b1, 1'b1));
      if (cc[i].pass) push($sformatf("cc%0d_br", i), e_br());
      push($sformatf("cc%0d_f1", i), e_f1());
      drain();
    end

    // Reset while waiting on memory in F2
    MFC = 1'b0; IR_Out = 32'hE2010000;
    push("rw_f2", e_f2()); push("rw_f2_hold", e_f2());
    drain();
    RESET = 1'b1;
    push("rw_rst", e_rst()); drain();
    RESET = 1'b0; MFC = 1'b1;
    push("rw_f1", e_f1()); push("rw_f2_after", e_f2());
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
